// File: rtl/gen_m0_mem_rsp.sv
// Memory responder for the gen_m0 master port: accepts read/write bursts, stores
// write beats in an internal word memory and returns read beats / write responses.
module gen_m0_mem_rsp #(
  parameter int unsigned AXI_DW    = 512,
  parameter int unsigned AXI_AW    = 64,
  parameter int unsigned AXI_MIDW  = 4,
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic                  axi_clk,
  input  logic                  axi_rst,
  input  logic                  stall_i,
  input  logic [AXI_AW-1:0]     gen_m0_maddr,
  input  logic [1:0]            gen_m0_mburst,
  input  logic [3:0]            gen_m0_mcache,
  input  logic                  gen_m0_mlock,
  input  logic [2:0]            gen_m0_mprot,
  input  logic [2:0]            gen_m0_msize,
  input  logic [AXI_DW-1:0]     gen_m0_mdata,
  input  logic [AXI_DW/8-1:0]   gen_m0_mwstrb,
  input  logic [AXI_MIDW-1:0]   gen_m0_mid,
  input  logic [3:0]            gen_m0_mlen,
  input  logic                  gen_m0_mread,
  input  logic                  gen_m0_mwrite,
  input  logic                  gen_m0_mready,
  output logic                  gen_m0_saccept,
  output logic [AXI_DW-1:0]     gen_m0_sdata,
  output logic [AXI_MIDW-1:0]   gen_m0_sid,
  output logic                  gen_m0_slast,
  output logic [2:0]            gen_m0_sresp,
  output logic                  gen_m0_svalid
);

  localparam int unsigned IW  = $clog2(MEM_DEPTH);
  localparam int unsigned OFF = $clog2(AXI_DW / 8);
  localparam int unsigned NB  = AXI_DW / 8;

  typedef enum logic [1:0] {StIdle, StWrData, StWrResp, StRdData} state_e;

  state_e              state_q, state_d;
  logic [AXI_MIDW-1:0] mid_q, mid_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          len_q, len_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [AXI_DW-1:0]   rdata_q;

  logic [AXI_DW-1:0]   mem [MEM_DEPTH];

  logic [IW-1:0]       addr_idx;
  logic [IW-1:0]       next_idx;
  logic                is_last;
  logic                mem_we;
  logic [IW-1:0]       mem_widx;
  logic                mem_re;
  logic [IW-1:0]       mem_ridx;
  logic                unused_ok;

  assign unused_ok = ^{gen_m0_mcache, gen_m0_mlock, gen_m0_mprot, gen_m0_msize, gen_m0_maddr};

  assign addr_idx = gen_m0_maddr[OFF +: IW];
  assign next_idx = (burst_q == 2'b01) ? idx_q + IW'(1) : idx_q;
  assign is_last  = (cnt_q == {1'b0, len_q});

  assign gen_m0_saccept = !stall_i && ((state_q == StIdle) || (state_q == StWrData));

  always_comb begin
    state_d  = state_q;
    mid_d    = mid_q;
    burst_d  = burst_q;
    len_d    = len_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    mem_widx = idx_q;
    mem_re   = 1'b0;
    mem_ridx = idx_q;
    unique case (state_q)
      StIdle: begin
        // Write wins over a simultaneous read; the master keeps mread asserted.
        if (gen_m0_mwrite && gen_m0_saccept) begin
          mid_d    = gen_m0_mid;
          burst_d  = gen_m0_mburst;
          len_d    = gen_m0_mlen;
          cnt_d    = 5'd1;
          mem_we   = !gen_m0_mburst[1];
          mem_widx = addr_idx;
          idx_d    = (gen_m0_mburst == 2'b01) ? addr_idx + IW'(1) : addr_idx;
          state_d  = (gen_m0_mlen == 4'd0) ? StWrResp : StWrData;
        end else if (gen_m0_mread && gen_m0_saccept) begin
          mid_d    = gen_m0_mid;
          burst_d  = gen_m0_mburst;
          len_d    = gen_m0_mlen;
          cnt_d    = 5'd0;
          idx_d    = addr_idx;
          mem_re   = !gen_m0_mburst[1];
          mem_ridx = addr_idx;
          state_d  = StRdData;
        end
      end
      StWrData: begin
        if (gen_m0_mwrite && gen_m0_saccept) begin
          mem_we   = !burst_q[1];
          mem_widx = idx_q;
          idx_d    = next_idx;
          cnt_d    = cnt_q + 5'd1;
          if (is_last) state_d = StWrResp;
        end
      end
      StWrResp: begin
        if (gen_m0_mready) state_d = StIdle;
      end
      StRdData: begin
        if (gen_m0_mready) begin
          if (is_last) begin
            state_d = StIdle;
          end else begin
            idx_d    = next_idx;
            cnt_d    = cnt_q + 5'd1;
            mem_re   = !burst_q[1];
            mem_ridx = next_idx;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q <= StIdle;
      mid_q   <= '0;
      burst_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mid_q   <= mid_d;
      burst_q <= burst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  // Memory and read register are not reset; outputs are gated by state instead.
  always_ff @(posedge axi_clk) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (gen_m0_mwstrb[b]) mem[mem_widx][b*8 +: 8] <= gen_m0_mdata[b*8 +: 8];
      end
    end
    if (mem_re) rdata_q <= mem[mem_ridx];
  end

  always_comb begin
    gen_m0_svalid = (state_q == StWrResp) || (state_q == StRdData);
    gen_m0_slast  = (state_q == StWrResp) || ((state_q == StRdData) && is_last);
    gen_m0_sid    = gen_m0_svalid ? mid_q : '0;
    gen_m0_sresp  = (gen_m0_svalid && burst_q[1]) ? 3'b010 : 3'b000;
    gen_m0_sdata  = ((state_q == StRdData) && !burst_q[1]) ? rdata_q : '0;
  end

endmodule

// File: doc/gen_m0_mem_rsp.md
# gen_m0_mem_rsp

Behavioural-synthesizable responder for the gen_m0 master port driven by the reverse interface. It accepts gen_m0 read/write burst commands, stores write beats in an internal AXI_DW-wide memory, and returns read beats and write responses on the sdata/svalid/slast/sid/sresp path. It serves as the memory end of gen_m0 in the reverse golden-model bench and as the reference model for the `if` block's DMA behaviour.

## Interface
- AXI_DW, 512, data width in bits
- AXI_AW, 64, address width
- AXI_MIDW, 4, ID width
- MEM_DEPTH, 1024, memory words (power of two); index bits IW = log2(MEM_DEPTH)
- axi_clk  input  1  clock, rising edge
- axi_rst  input  1  reset, asynchronous, active-high
- stall_i  input  1  bench back-pressure; 1 forces gen_m0_saccept low
- gen_m0_maddr  input  AXI_AW  byte address (first beat / command only)
- gen_m0_mburst  input  2  00 FIXED, 01 INCR, others unsupported
- gen_m0_mcache / mlock / mprot / msize  input  4/1/3/3  ignored; full-width beats
- gen_m0_mdata  input  AXI_DW  write beat data
- gen_m0_mwstrb  input  AXI_DW/8  byte enables per write beat
- gen_m0_mid  input  AXI_MIDW  transaction ID
- gen_m0_mlen  input  4  beats minus one (1..16 beats)
- gen_m0_mread  input  1  read command request
- gen_m0_mwrite  input  1  write beat valid (first beat carries command)
- gen_m0_mready  input  1  master accepts response beat
- gen_m0_saccept  output  1  command / write beat accepted this cycle
- gen_m0_sdata  output  AXI_DW  read data (0 on write response)
- gen_m0_sid  output  AXI_MIDW  ID of the response
- gen_m0_slast  output  1  final response beat
- gen_m0_sresp  output  3  000 OKAY, 010 SLVERR
- gen_m0_svalid  output  1  response beat valid

## Operation
- Word index = maddr[6 +: IW] (byte offset log2(AXI_DW/8)=6 dropped); upper bits ignored, index wraps modulo MEM_DEPTH.
- INCR: index +1 per beat, wraps MEM_DEPTH-1 -> 0. FIXED: index constant.
- mburst 10/11: SLVERR; burst runs its full beat count with no memory access; read beats return sdata=0.
- FSM states: IDLE, WR_DATA, WR_RESP, RD_DATA.
- saccept = !stall_i && (state==IDLE || state==WR_DATA); combinational.
- IDLE: mwrite&saccept -> latch mid, mburst, mlen, index; write beat 0 under mwstrb; mlen==0 -> WR_RESP else WR_DATA, beat count=1. Else mread&saccept -> latch fields, register read of word index -> RD_DATA. mwrite and mread both high: write wins, read stays pending (master holds it).
- WR_DATA: each mwrite&saccept writes beat under mwstrb at current index, advances index/count; beat mlen -> WR_RESP. mread ignored.
- WR_RESP: svalid=1, slast=1, sid=latched mid, sresp, sdata=0; hold until mready -> IDLE.
- RD_DATA: svalid=1, sdata=registered word, sid, sresp; slast=1 on beat mlen. On svalid&mready: last beat -> IDLE (svalid drops next cycle); else read next index, next beat valid next cycle.
- Byte lanes with mwstrb bit 0 retain previous contents.
- Memory contents not reset; undefined until written.

## Timing
- Reset: state IDLE, svalid=0, slast=0, sid=0, sresp=0, sdata=0, internal counters 0; saccept = !stall_i combinationally.
- Read: command accepted cycle N -> beat 0 valid N+1; with mready held high one beat per cycle, last beat at N+1+mlen.
- Response beats held stable (sdata/sid/sresp/slast) while svalid&!mready.
- Write: beats accepted one per cycle when saccept; response svalid at cycle after last beat accepted; latency 1.
- Read-after-write to same word sees new data (write completes before WR_RESP).
- Reset asserted mid-burst: burst discarded, outputs return to reset values asynchronously; partially written words keep written beats.
- No outstanding overlap: single transaction at a time.

## Test plan
- Write INCR maddr=0x40, mlen=3, data 0xA0..0xA3 full strobes, mid=5 -> saccept 4 consecutive cycles, one response svalid/slast=1, sid=5, sresp=000; then read same -> beats 0xA0..0xA3 at N+1..N+4, slast on 4th.
- Partial strobe: write word 0 all 0xFF, then mwstrb=bit0 only with data 0x11 -> read returns byte0=0x11, all other bytes 0xFF.
- Wrap: INCR write at index MEM_DEPTH-1, mlen=1 -> second beat stored at index 0; read index 0 confirms.
- Back-pressure: read mlen=7 with mready toggling 1/0 and stall_i=1 for 3 cycles before command -> no accept during stall, beats held stable while mready=0, 8 beats in order, no duplicates/losses.
- mburst=2'b10 write mlen=1 -> 2 beats accepted, response sresp=010, memory unchanged; mread&mwrite simultaneous in IDLE -> write served first, read served after WR_RESP.
- axi_rst pulse during read beat 2 of 4 -> svalid=0 immediately, state IDLE, next read command completes normally.
